// File: rtl/regfile_mp.sv
// Multi-port byte-addressed register file: NWR word writes and NRD word/byte/passthrough
// reads per cycle. Addresses wrap, writes are merged highest-port-wins, reads are write-first.
module regfile_mp #(
  parameter int WORD       = 4,
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int NRD        = 3,
  parameter int NWR        = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NRD*ADDR_WIDTH-1:0]   rd_addr,
  input  logic [NRD-1:0]              rd_en,
  input  logic [NRD-1:0]              rd_byte,
  input  logic [NRD-1:0]              rd_pt,
  input  logic [NRD*WORD*WIDTH-1:0]   rd_ptval,
  output logic [NRD*WORD*WIDTH-1:0]   rd_data,
  output logic [NRD-1:0]              rd_valid,
  input  logic [NWR-1:0]              we,
  input  logic [NWR*ADDR_WIDTH-1:0]   wa,
  input  logic [NWR*WORD*WIDTH-1:0]   wd,
  input  logic [NWR*WORD-1:0]         wbe
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int DW    = WORD * WIDTH;

  logic [DEPTH-1:0][WIDTH-1:0] mem, mem_nxt;

  // Later (higher-index) ports overwrite earlier ones, giving highest-port-wins per cell.
  always_comb begin
    logic [ADDR_WIDTH-1:0] wcell;
    wcell   = '0;
    mem_nxt = mem;
    for (int j = 0; j < NWR; j++)
      for (int k = 0; k < WORD; k++)
        if (we[j] && wbe[j*WORD+k]) begin
          wcell          = wa[j*ADDR_WIDTH +: ADDR_WIDTH] + ADDR_WIDTH'(k);
          mem_nxt[wcell] = wd[j*DW + k*WIDTH +: WIDTH];
        end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) mem <= '0;
    else     mem <= mem_nxt;

  // Lanes read the post-write image, which makes same-edge reads write-first per byte.
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    regfile_mp_rd_lane #(
      .WORD(WORD), .WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .en      (rd_en[i]),
      .byte_rd (rd_byte[i]),
      .pt      (rd_pt[i]),
      .ptval   (rd_ptval[i*DW +: DW]),
      .addr    (rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]),
      .cells   (mem_nxt),
      .data    (rd_data[i*DW +: DW]),
      .valid   (rd_valid[i])
    );
  end
endmodule

// One read port: selects passthrough, byte or word view and registers it.
module regfile_mp_rd_lane #(
  parameter int WORD       = 4,
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 en,
  input  logic                                 byte_rd,
  input  logic                                 pt,
  input  logic [WORD*WIDTH-1:0]                ptval,
  input  logic [ADDR_WIDTH-1:0]                addr,
  input  logic [(1<<ADDR_WIDTH)-1:0][WIDTH-1:0] cells,
  output logic [WORD*WIDTH-1:0]                data,
  output logic                                 valid
);
  logic [WORD*WIDTH-1:0] word_nxt;

  always_comb begin
    word_nxt = '0;
    for (int k = 0; k < WORD; k++)
      if (!byte_rd || k == 0)
        word_nxt[k*WIDTH +: WIDTH] = cells[addr + ADDR_WIDTH'(k)];
    if (pt) word_nxt = ptval;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      data  <= '0;
      valid <= 1'b0;
    end else begin
      valid <= en;
      if (en) data <= word_nxt;
    end
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp with default parameters (3 read, 2 write ports, 16 cells).
module tb_regfile_mp;
  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] rd_addr;
  logic [2:0]  rd_en, rd_byte, rd_pt;
  logic [95:0] rd_ptval;
  logic [95:0] rd_data;
  logic [2:0]  rd_valid;
  logic [1:0]  we;
  logic [7:0]  wa;
  logic [63:0] wd;
  logic [7:0]  wbe;

  int n_chk  = 0;
  int n_fail = 0;

  regfile_mp dut (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_byte(rd_byte), .rd_pt(rd_pt),
    .rd_ptval(rd_ptval), .rd_data(rd_data), .rd_valid(rd_valid),
    .we(we), .wa(wa), .wd(wd), .wbe(wbe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_addr = '0; rd_en = '0; rd_byte = '0; rd_pt = '0; rd_ptval = '0;
    we = '0; wa = '0; wd = '0; wbe = '0;
  endtask

  task automatic rd(input int i, input logic [3:0] a, input logic b);
    rd_en[i] = 1'b1;
    rd_byte[i] = b;
    rd_addr[i*4 +: 4] = a;
  endtask

  task automatic wr(input int j, input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    we[j] = 1'b1;
    wa[j*4 +: 4] = a;
    wd[j*32 +: 32] = d;
    wbe[j*4 +: 4] = be;
  endtask

  initial begin
    // Reset with garbage traffic: writes target cell 0 and must be discarded
    rst = 1'b1;
    rd_addr = 12'h5a3; rd_en = 3'b111; rd_byte = 3'b010; rd_pt = 3'b001;
    rd_ptval = {3{32'hcafef00d}};
    we = 2'b11; wa = 8'h00; wd = 64'hffee_ddcc_bbaa_9988; wbe = 8'hff;
    cyc(); cyc();
    chk("rst_data", rd_data, 96'h0);
    chk("rst_valid", {93'h0, rd_valid}, 96'h0);
    idle();
    rst = 1'b0;

    rd(0, 4'h0, 1'b0);
    cyc();
    chk("post_rst_rd0", rd_data[31:0], 32'h0000_0000);
    chk("post_rst_vld", {93'h0, rd_valid}, 96'h1);
    idle();

    // Basic write then read one cycle later
    wr(0, 4'h4, 32'hdead_beef, 4'hf);
    cyc();
    idle();
    rd(1, 4'h4, 1'b0);
    cyc();
    chk("basic_data", rd_data[63:32], 32'hdead_beef);
    chk("basic_vld", {93'h0, rd_valid}, 96'h2);
    idle();

    // Wrapping write: E=44 F=33 0=22 1=11
    wr(1, 4'he, 32'h1122_3344, 4'hf);
    cyc();
    idle();
    rd(0, 4'he, 1'b0);
    rd(1, 4'h1, 1'b1);
    rd(2, 4'h0, 1'b1);
    cyc();
    chk("wrap_word", rd_data[31:0], 32'h1122_3344);
    chk("byte_c1", rd_data[63:32], 32'h0000_0011);
    chk("byte_c0", rd_data[95:64], 32'h0000_0022);
    chk("wrap_vld", {93'h0, rd_valid}, 96'h7);
    idle();

    // Collision with same-edge read: port1 wins bytes 2,3
    wr(0, 4'h8, 32'haaaa_aaaa, 4'hf);
    wr(1, 4'h8, 32'h5555_1234, 4'hc);
    rd(0, 4'h8, 1'b0);
    cyc();
    chk("coll_bypass", rd_data[31:0], 32'h5555_aaaa);
    idle();
    rd(2, 4'h8, 1'b0);
    cyc();
    chk("coll_stored", rd_data[95:64], 32'h5555_aaaa);
    idle();

    // Partial write, then next-cycle write overlapping a same-edge read
    wr(0, 4'h4, 32'h0000_00ff, 4'h1);
    cyc();
    idle();
    wr(1, 4'h5, 32'h0000_0077, 4'h1);
    rd(0, 4'h4, 1'b0);
    cyc();
    chk("b2b_write_first", rd_data[31:0], 32'hdead_77ff);
    idle();

    // Passthrough ignores rd_byte, then hold with rd_en low
    rd(1, 4'h4, 1'b1);
    rd_pt[1] = 1'b1;
    rd_ptval[63:32] = 32'h1234_5678;
    cyc();
    chk("pt_data", rd_data[63:32], 32'h1234_5678);
    chk("pt_vld", {93'h0, rd_valid}, 96'h2);
    idle();
    cyc();
    chk("hold_data", rd_data[63:32], 32'h1234_5678);
    chk("hold_vld", {93'h0, rd_valid}, 96'h0);

    // Mid-operation reset clears outputs without a clock edge
    rd(0, 4'h4, 1'b0); rd(1, 4'h8, 1'b0); rd(2, 4'he, 1'b0);
    cyc();
    chk("pre_rst_vld", {93'h0, rd_valid}, 96'h7);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_data", rd_data, 96'h0);
    chk("async_rst_vld", {93'h0, rd_valid}, 96'h0);
    cyc();
    idle();
    rst = 1'b0;
    rd(0, 4'h4, 1'b0);
    cyc();
    chk("cells_cleared", rd_data[31:0], 32'h0000_0000);
    idle();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
